// File: rtl/bsg_sipo_pkg.sv
// ---------------------------------------------------------------------------
// bsg_sipo_pkg
// Shared helpers for the buffered serial-in/parallel-out deserializer.
//   sipo_cnt_width : width of the word-index counter, never less than 1 bit.
//   sipo_map_idx   : maps a received-word index onto its data_o slot.
// No ports (package).
// ---------------------------------------------------------------------------
package bsg_sipo_pkg;

  localparam int SIPO_LO_TO_HI = 0;
  localparam int SIPO_HI_TO_LO = 1;

  // max(1, $clog2(els)); a 1- or 2-word frame still needs a 1-bit counter.
  function automatic int sipo_cnt_width(input int els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

  // With hi_to_lo ordering the first received word ends up in the top slot.
  function automatic int sipo_map_idx(input int idx, input int els, input int hi_to_lo);
    return (hi_to_lo == SIPO_HI_TO_LO) ? (els - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/bsg_serial_in_parallel_out_buffered_if.sv
// ---------------------------------------------------------------------------
// bsg_serial_in_parallel_out_buffered_if
// Bundles the serial (ready/valid) input side and the parallel (valid/yumi)
// output side of the deserializer. Signal suffixes are from the deserializer's
// point of view.
// Handshakes:
//   serial  : a word transfers on a rising clk edge where valid_i & ready_o;
//             ready_o does not depend on valid_i or yumi_i in the same cycle.
//   parallel: data_o is held while valid_o=1; the consumer raises yumi_i for
//             one cycle (only while valid_o=1) to take the frame.
// Modports: slave = deserializer, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface bsg_serial_in_parallel_out_buffered_if #(
  parameter int width_p = -1,
  parameter int els_p   = -1
);
  logic                            valid_i;
  logic [width_p-1:0]              data_i;
  logic                            ready_o;
  logic                            valid_o;
  logic [els_p-1:0][width_p-1:0]   data_o;
  logic                            yumi_i;

  modport slave  (input  valid_i, data_i, yumi_i,
                  output ready_o, valid_o, data_o);
  modport master (output valid_i, data_i, yumi_i,
                  input  ready_o, valid_o, data_o);
endinterface

// File: rtl/bsg_sipo_stage_ctr.sv
// ---------------------------------------------------------------------------
// bsg_sipo_stage_ctr
// Wrapping word-index counter 0..els_p-1 with increment enable.
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low clear
//   en_i      : advance by one (wraps from els_p-1 to 0)
//   cnt_o     : current index
//   last_o    : cnt_o == els_p-1
// ---------------------------------------------------------------------------
module bsg_sipo_stage_ctr
  import bsg_sipo_pkg::*;
#(
  parameter  int els_p = -1,
  localparam int cw_lp = sipo_cnt_width(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  output logic [cw_lp-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [cw_lp-1:0] max_lp = cw_lp'(els_p - 1);

  logic [cw_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == max_lp) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == max_lp);

endmodule

// File: rtl/bsg_serial_in_parallel_out_buffered.sv
// ---------------------------------------------------------------------------
// bsg_serial_in_parallel_out_buffered
// Collects els_p consecutive width_p-bit words into one frame. Words are
// staged separately from the output register so the next frame can be
// assembled while the previous one waits for yumi.
// Ports:
//   clk_i        : clock
//   reset_n_i    : asynchronous active-low reset
//   link         : slave modport (valid_i/data_i/ready_o, valid_o/data_o/yumi_i)
//   fill_count_o : words currently staged (only with BSG_SIPO_STATUS_EN)
// Parameters: width_p, els_p (>=1), hi_to_lo_p (1: first word in top slot).
// Optional: define BSG_SIPO_STATUS_EN for fill_count_o and a counter-range
// assertion; the datapath is the same either way.
// ---------------------------------------------------------------------------
module bsg_serial_in_parallel_out_buffered
  import bsg_sipo_pkg::*;
#(
  parameter int width_p    = -1,
  parameter int els_p      = -1,
  parameter int hi_to_lo_p = 0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_serial_in_parallel_out_buffered_if.slave link
`ifdef BSG_SIPO_STATUS_EN
  , output logic [$clog2(els_p+1)-1:0] fill_count_o
`endif
);

  localparam int cw_lp = sipo_cnt_width(els_p);
`ifdef BSG_SIPO_STATUS_EN
  localparam int fcw_lp = $clog2(els_p + 1);
`endif

  typedef logic [width_p-1:0] word_t;

  word_t [els_p-1:0] frame_d, out_q;
  logic              out_v_q, out_v_d;
  logic              ready, accept, load;

  assign accept = link.valid_i & ready;

  if (els_p == 1) begin : g_single
    // Single-word frames: no staging, so the output register must be empty
    // before a word can be taken (one bubble per word).
    assign ready   = ~out_v_q;
    assign load    = accept;
    assign frame_d = link.data_i;
`ifdef BSG_SIPO_STATUS_EN
    assign fill_count_o = '0;
`endif
  end else begin : g_multi
    word_t            stage_q [els_p-2:0];
    logic [cw_lp-1:0] cnt;
    logic             last;

    bsg_sipo_stage_ctr #(.els_p(els_p)) u_ctr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (accept),
      .cnt_o     (cnt),
      .last_o    (last)
    );

    // Only the last word needs the output register free; earlier words go
    // to staging and may arrive while a frame is still pending.
    assign ready = ~last | ~out_v_q;
    assign load  = accept & last;

    always_ff @(posedge clk_i) begin
      if (accept && !last) stage_q[cnt] <= link.data_i;
    end

    always_comb begin
      for (int i = 0; i < els_p - 1; i++) frame_d[i] = stage_q[i];
      frame_d[els_p-1] = link.data_i;
    end

`ifdef BSG_SIPO_STATUS_EN
    assign fill_count_o = fcw_lp'(cnt);

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      cnt <= cw_lp'(els_p - 1));
`endif
  end

  // A frame load wins over a same-cycle yumi so a fresh frame is never lost.
  always_comb begin
    out_v_d = out_v_q;
    if (load)             out_v_d = 1'b1;
    else if (link.yumi_i) out_v_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) out_v_q <= 1'b0;
    else            out_v_q <= out_v_d;
  end

  always_ff @(posedge clk_i) begin
    if (load) out_q <= frame_d;
  end

  for (genvar i = 0; i < els_p; i++) begin : g_map
    assign link.data_o[i] = out_q[sipo_map_idx(i, els_p, hi_to_lo_p)];
  end

  assign link.ready_o = ready;
  assign link.valid_o = out_v_q;

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    link.yumi_i |-> out_v_q);

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_buffered.sv
`timescale 1ns/1ps
module tb_bsg_serial_in_parallel_out_buffered;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: lo_to_hi 8x4, b: hi_to_lo 8x4, c: single-word frames
  bsg_serial_in_parallel_out_buffered_if #(.width_p(8), .els_p(4)) a_if ();
  bsg_serial_in_parallel_out_buffered_if #(.width_p(8), .els_p(4)) b_if ();
  bsg_serial_in_parallel_out_buffered_if #(.width_p(8), .els_p(1)) c_if ();

`ifdef BSG_SIPO_STATUS_EN
  logic [2:0] fc_a, fc_b;
  logic [0:0] fc_c;
`endif

  bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(4), .hi_to_lo_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .link(a_if.slave)
`ifdef BSG_SIPO_STATUS_EN
    , .fill_count_o(fc_a)
`endif
  );
  bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(4), .hi_to_lo_p(1)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .link(b_if.slave)
`ifdef BSG_SIPO_STATUS_EN
    , .fill_count_o(fc_b)
`endif
  );
  bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(1), .hi_to_lo_p(0)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .link(c_if.slave)
`ifdef BSG_SIPO_STATUS_EN
    , .fill_count_o(fc_c)
`endif
  );

  // ---------------- scoreboard / reference state ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [7:0]  exp_q2[$];
  int          mc [2];
  bit          mv [2];
  logic [7:0]  mw [2][4];
  bit          mv_c;

  task automatic clear_model();
    mc[0] = 0; mc[1] = 0; mv[0] = 0; mv[1] = 0; mv_c = 0;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One cycle on the 4-word DUT s (0=a, 1=b): check outputs against the
  // reference, then drive the inputs for the coming rising edge.
  // y requests a yumi; it is only issued while a frame is expected valid.
  task automatic cycle4(input int s, input logic v, input logic [7:0] d,
                        input logic y, input string tag);
    logic        rdy, vo, exp_rdy, yy, acc, last, have;
    logic [31:0] dout, e, frame;
    @(negedge clk);
    rdy  = (s == 0) ? a_if.ready_o : b_if.ready_o;
    vo   = (s == 0) ? a_if.valid_o : b_if.valid_o;
    dout = (s == 0) ? a_if.data_o  : b_if.data_o;
    exp_rdy = (mc[s] != 3) || !mv[s];
    checks++;
    if (rdy !== exp_rdy) begin
      errors++; $display("FAIL %s ready_o got %b exp %b", tag, rdy, exp_rdy);
    end
    checks++;
    if (vo !== mv[s]) begin
      errors++; $display("FAIL %s valid_o got %b exp %b", tag, vo, mv[s]);
    end
`ifdef BSG_SIPO_STATUS_EN
    checks++;
    if (((s == 0) ? fc_a : fc_b) !== 3'(mc[s])) begin
      errors++; $display("FAIL %s fill_count_o got %0d exp %0d", tag,
                         (s == 0) ? fc_a : fc_b, mc[s]);
    end
`endif
    yy = y & mv[s];
    if (mv[s]) begin
      have = (s == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      e    = (s == 0) ? (have ? exp_q0[0] : 32'h0) : (have ? exp_q1[0] : 32'h0);
      checks++;
      if (!have) begin
        errors++; $display("FAIL %s data_o got %h exp <no frame queued>", tag, dout);
      end else if (dout !== e) begin
        errors++; $display("FAIL %s data_o got %h exp %h", tag, dout, e);
      end
      if (yy && have) begin
        if (s == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      end
    end
    if (s == 0) begin a_if.valid_i = v; a_if.data_i = d; a_if.yumi_i = yy; end
    else        begin b_if.valid_i = v; b_if.data_i = d; b_if.yumi_i = yy; end
    acc  = v & exp_rdy;
    last = (mc[s] == 3);
    if (acc) begin
      mw[s][mc[s]] = d;
      if (last) begin
        for (int i = 0; i < 4; i++) begin
          if (s == 0) frame[8*i +: 8]     = mw[s][i];
          else        frame[8*(3-i) +: 8] = mw[s][i];
        end
        if (s == 0) exp_q0.push_back(frame); else exp_q1.push_back(frame);
        mc[s] = 0;
      end else begin
        mc[s] = mc[s] + 1;
      end
    end
    if (acc && last) mv[s] = 1;
    else if (yy)     mv[s] = 0;
  endtask

  // One cycle on the single-word DUT.
  task automatic cycle1(input logic v, input logic [7:0] d, input logic y,
                        input string tag);
    logic exp_rdy, yy;
    @(negedge clk);
    exp_rdy = !mv_c;
    checks++;
    if (c_if.ready_o !== exp_rdy) begin
      errors++; $display("FAIL %s ready_o got %b exp %b", tag, c_if.ready_o, exp_rdy);
    end
    checks++;
    if (c_if.valid_o !== mv_c) begin
      errors++; $display("FAIL %s valid_o got %b exp %b", tag, c_if.valid_o, mv_c);
    end
`ifdef BSG_SIPO_STATUS_EN
    checks++;
    if (fc_c !== 1'b0) begin
      errors++; $display("FAIL %s fill_count_o got %0d exp 0", tag, fc_c);
    end
`endif
    yy = y & mv_c;
    if (mv_c) begin
      checks++;
      if (exp_q2.size() == 0) begin
        errors++; $display("FAIL %s data_o got %h exp <no word queued>", tag, c_if.data_o);
      end else begin
        if (c_if.data_o !== exp_q2[0]) begin
          errors++; $display("FAIL %s data_o got %h exp %h", tag, c_if.data_o, exp_q2[0]);
        end
        if (yy) void'(exp_q2.pop_front());
      end
    end
    c_if.valid_i = v; c_if.data_i = d; c_if.yumi_i = yy;
    if (v && exp_rdy) begin exp_q2.push_back(d); mv_c = 1; end
    else if (yy)      mv_c = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_if.valid_o !== 1'b0 || b_if.valid_o !== 1'b0 || c_if.valid_o !== 1'b0) begin
      errors++; $display("FAIL reset valid_o got %b%b%b exp 000",
                         a_if.valid_o, b_if.valid_o, c_if.valid_o);
    end
    checks++;
    if (a_if.ready_o !== 1'b1 || b_if.ready_o !== 1'b1 || c_if.ready_o !== 1'b1) begin
      errors++; $display("FAIL reset ready_o got %b%b%b exp 111",
                         a_if.ready_o, b_if.ready_o, c_if.ready_o);
    end
  endtask

  task automatic test_stream();
    logic [7:0] w [4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    for (int i = 0; i < 4; i++) cycle4(0, 1'b1, w[i], 1'b1, "stream");
    cycle4(0, 1'b0, 8'h00, 1'b1, "stream_out");
    cycle4(0, 1'b0, 8'h00, 1'b0, "stream_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) cycle4(0, 1'b1, 8'(i), 1'b1, "b2b");
    cycle4(0, 1'b0, 8'h00, 1'b1, "b2b_out");
    cycle4(0, 1'b0, 8'h00, 1'b0, "b2b_idle");
  endtask

  task automatic test_stall();
    for (int i = 1; i <= 7; i++) cycle4(0, 1'b1, 8'(i), 1'b0, "stall_fill");
    for (int k = 0; k < 3; k++) cycle4(0, 1'b1, 8'h08, 1'b0, "stall_hold");
    cycle4(0, 1'b1, 8'h08, 1'b1, "stall_yumi");
    cycle4(0, 1'b1, 8'h08, 1'b0, "stall_accept");
    cycle4(0, 1'b0, 8'h00, 1'b0, "stall_wait");
    cycle4(0, 1'b0, 8'h00, 1'b1, "stall_out");
    cycle4(0, 1'b0, 8'h00, 1'b0, "stall_idle");
  endtask

  task automatic test_hi_to_lo();
    logic [7:0] w [4];
    w[0] = 8'hAA; w[1] = 8'hBB; w[2] = 8'hCC; w[3] = 8'hDD;
    for (int i = 0; i < 4; i++) cycle4(1, 1'b1, w[i], 1'b0, "rev");
    cycle4(1, 1'b0, 8'h00, 1'b1, "rev_out");
    cycle4(1, 1'b0, 8'h00, 1'b0, "rev_idle");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) cycle4(0, 1'b1, 8'h61 + 8'(i), 1'b0, "mr_frame");
    cycle4(0, 1'b1, 8'h71, 1'b0, "mr_part");
    cycle4(0, 1'b1, 8'h72, 1'b0, "mr_part");
    @(posedge clk);
    #2;
    a_if.valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_if.valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset valid_o got %b exp 0", a_if.valid_o);
    end
    checks++;
    if (a_if.ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset ready_o got %b exp 1", a_if.ready_o);
    end
`ifdef BSG_SIPO_STATUS_EN
    checks++;
    if (fc_a !== 3'd0) begin
      errors++; $display("FAIL mid_reset fill_count_o got %0d exp 0", fc_a);
    end
`endif
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle4(0, 1'b1, 8'h81 + 8'(i), 1'b0, "mr_clean");
    cycle4(0, 1'b0, 8'h00, 1'b1, "mr_out");
    cycle4(0, 1'b0, 8'h00, 1'b0, "mr_idle");
  endtask

  task automatic test_single();
    cycle1(1'b1, 8'h5A, 1'b0, "one_first");
    cycle1(1'b1, 8'h5B, 1'b0, "one_block");
    cycle1(1'b1, 8'h5B, 1'b0, "one_block");
    cycle1(1'b1, 8'h5B, 1'b1, "one_yumi");
    cycle1(1'b1, 8'h5B, 1'b0, "one_accept");
    cycle1(1'b0, 8'h00, 1'b0, "one_wait");
    cycle1(1'b0, 8'h00, 1'b1, "one_out");
    cycle1(1'b0, 8'h00, 1'b0, "one_idle");
  endtask

  task automatic test_random();
    logic v, y;
    for (int n = 0; n < 200; n++) begin
      v = ($urandom_range(0, 3) != 0);
      y = ($urandom_range(0, 2) == 0);
      cycle4(0, v, 8'($urandom_range(0, 255)), y, "random");
    end
    for (int n = 0; n < 6; n++) cycle4(0, 1'b0, 8'h00, 1'b1, "random_drain");
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    a_if.valid_i = 1'b0; a_if.data_i = '0; a_if.yumi_i = 1'b0;
    b_if.valid_i = 1'b0; b_if.data_i = '0; b_if.yumi_i = 1'b0;
    c_if.valid_i = 1'b0; c_if.data_i = '0; c_if.yumi_i = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_stream();
    test_back_to_back();
    test_stall();
    test_hi_to_lo();
    test_mid_reset();
    test_single();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
